// File: rtl/cs_field_sequencer.sv
// cs_field_sequencer: registered chip-select generator for the RTC config
// register groups. Selects a whole group (BULK) or a single field under a
// next/prev cursor (EDIT), with an optional EDIT inactivity timeout.
module cs_field_sequencer #(
  parameter int                      N_GROUPS    = 3,
  parameter int                      MAX_FIELDS  = 4,
  parameter logic [4*N_GROUPS-1:0]   GROUP_SIZES = 12'h343,
  parameter int                      TIMEOUT_CYC = 0,
  localparam int                     SEL_W       = $clog2(N_GROUPS + 1),
  localparam int                     CUR_W       = (MAX_FIELDS > 1) ? $clog2(MAX_FIELDS) : 1,
  localparam int                     CS_W        = N_GROUPS * MAX_FIELDS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] funcion_conf,
  input  logic             edit_en,
  input  logic             btn_next,
  input  logic             btn_prev,
  output logic [CS_W-1:0]  cs,
  output logic [SEL_W-1:0] active_group,
  output logic [CUR_W-1:0] cursor,
  output logic             editing,
  output logic             edit_timeout
);

  // Timer only needs to reach TIMEOUT_CYC-1; it saturates at all-ones.
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BULK = 2'd1,
    ST_EDIT = 2'd2
  } state_t;

  state_t            r_state;
  logic [CS_W-1:0]   r_cs;
  logic [SEL_W-1:0]  r_active_group;
  logic [CUR_W-1:0]  r_cursor;
  logic              r_editing;
  logic              r_edit_timeout;
  logic              r_edit_en_d;
  logic [TMR_W-1:0]  r_timer;

  // Per-group lookup tables; entry 0 stands for "no group" and is all zero.
  logic [N_GROUPS:0][CS_W-1:0] w_bulk_cs;
  logic [N_GROUPS:0][3:0]      w_grp_size;

  logic             w_conf_valid;
  logic [SEL_W-1:0] w_conf_grp;
  logic             w_edit_rise;
  logic             w_any_btn;
  logic             w_timeout_hit;
  logic [3:0]       w_ag_size;
  logic [CUR_W-1:0] w_cur_next;

  assign w_bulk_cs[0]  = '0;
  assign w_grp_size[0] = '0;

  generate
    for (genvar gi = 0; gi < N_GROUPS; gi++) begin : g_grp
      // Sizes above MAX_FIELDS are clamped so no out-of-group bit can assert.
      localparam int RAW = int'(GROUP_SIZES[4*gi +: 4]);
      localparam int SZ  = (RAW > MAX_FIELDS) ? MAX_FIELDS : RAW;
      localparam logic [CS_W-1:0] MASK = CS_W'((1 << SZ) - 1) << (gi * MAX_FIELDS);
      assign w_bulk_cs[gi+1]  = MASK;
      assign w_grp_size[gi+1] = 4'(SZ);
    end
  endgenerate

  // Out-of-range group codes collapse to 0 so they behave like "none".
  assign w_conf_valid  = (funcion_conf != '0) && (int'(funcion_conf) <= N_GROUPS);
  assign w_conf_grp    = w_conf_valid ? funcion_conf : '0;
  assign w_edit_rise   = edit_en & ~r_edit_en_d;
  assign w_any_btn     = btn_next | btn_prev;
  assign w_ag_size     = w_grp_size[r_active_group];
  assign w_timeout_hit = (TIMEOUT_CYC > 0) && !w_any_btn &&
                         (r_timer == TMR_W'(TIMEOUT_CYC - 1));

  // One-hot select of a single field inside a group.
  function automatic logic [CS_W-1:0] field_cs(input logic [SEL_W-1:0] g,
                                               input logic [CUR_W-1:0] c);
    field_cs = '0;
    if (g != '0) field_cs = CS_W'(1) << ((int'(g) - 1) * MAX_FIELDS + int'(c));
  endfunction

  // Cursor step with wrap inside the active group; both buttons cancel out.
  always_comb begin
    w_cur_next = r_cursor;
    if (btn_next && !btn_prev) begin
      w_cur_next = (r_cursor == CUR_W'(w_ag_size - 4'd1)) ? '0 : r_cursor + CUR_W'(1);
    end else if (btn_prev && !btn_next) begin
      w_cur_next = (r_cursor == '0) ? CUR_W'(w_ag_size - 4'd1) : r_cursor - CUR_W'(1);
    end
  end

  // Main sequencer: state, chip selects and status outputs all registered here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_cs           <= '0;
      r_active_group <= '0;
      r_cursor       <= '0;
      r_editing      <= 1'b0;
      r_edit_timeout <= 1'b0;
      r_edit_en_d    <= 1'b0;
      r_timer        <= '0;
    end else begin
      r_edit_en_d    <= edit_en;
      r_edit_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_conf_valid) begin
            r_state        <= ST_BULK;
            r_active_group <= w_conf_grp;
            r_cursor       <= '0;
            r_cs           <= w_bulk_cs[w_conf_grp];
          end
        end
        ST_BULK: begin
          if (!w_conf_valid) begin
            r_state        <= ST_IDLE;
            r_active_group <= '0;
            r_cursor       <= '0;
            r_cs           <= '0;
          end else if (w_conf_grp != r_active_group) begin
            r_active_group <= w_conf_grp;
            r_cursor       <= '0;
            r_cs           <= w_bulk_cs[w_conf_grp];
          end else if (w_edit_rise) begin
            r_state   <= ST_EDIT;
            r_editing <= 1'b1;
            r_cursor  <= '0;
            r_timer   <= '0;
            r_cs      <= field_cs(r_active_group, '0);
          end
        end
        ST_EDIT: begin
          if (!w_conf_valid) begin
            r_state        <= ST_IDLE;
            r_editing      <= 1'b0;
            r_active_group <= '0;
            r_cursor       <= '0;
            r_cs           <= '0;
          end else if (w_conf_grp != r_active_group) begin
            r_state        <= ST_BULK;
            r_editing      <= 1'b0;
            r_active_group <= w_conf_grp;
            r_cursor       <= '0;
            r_cs           <= w_bulk_cs[w_conf_grp];
          end else if (!edit_en) begin
            r_state   <= ST_BULK;
            r_editing <= 1'b0;
            r_cursor  <= '0;
            r_cs      <= w_bulk_cs[r_active_group];
          end else if (w_timeout_hit) begin
            r_state        <= ST_BULK;
            r_editing      <= 1'b0;
            r_edit_timeout <= 1'b1;
            r_cursor       <= '0;
            r_cs           <= w_bulk_cs[r_active_group];
          end else begin
            r_cursor <= w_cur_next;
            r_cs     <= field_cs(r_active_group, w_cur_next);
            if (w_any_btn)            r_timer <= '0;
            else if (r_timer != '1)   r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          r_editing      <= 1'b0;
          r_active_group <= '0;
          r_cursor       <= '0;
          r_cs           <= '0;
        end
      endcase
    end
  end

  assign cs           = r_cs;
  assign active_group = r_active_group;
  assign cursor       = r_cursor;
  assign editing      = r_editing;
  assign edit_timeout = r_edit_timeout;

endmodule
